// File: rtl/vga_timing_pkg.sv
// Shared state encoding, default VGA timing and counter widths for the
// timing controller and its divider.
package vga_timing_pkg;
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_STOPPING = 2'd2;

  localparam int H_TOTAL      = 1600;
  localparam int H_ACTIVE     = 1280;
  localparam int V_TOTAL      = 521;
  localparam int V_ACTIVE     = 480;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 491;

  localparam int H_W = 11;
  localparam int V_W = 10;
endpackage

// File: rtl/vga_timing_controller_pixel_tick_divider.sv
// Pixel tick generator: counts system clocks while run is high and emits a
// registered one-clock tick each time the count wraps.
module pixel_tick_divider #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div  <= '0;
      tick <= 1'b0;
    end else if (!run) begin
      div  <= '0;
      tick <= 1'b0;
    end else if (div == DW'(CLK_DIV - 1)) begin
      div  <= '0;
      tick <= 1'b1;
    end else begin
      div  <= div + 1'b1;
      tick <= 1'b0;
    end
  end
endmodule

// File: rtl/vga_timing_controller.sv
// VGA scan sequencer: run/stop FSM with frame-aligned stop, pixel counters
// and the VSync / active-video / frame-start decodes.
module vga_timing_controller
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV         = 1,
  parameter int H_TOTAL_P       = H_TOTAL,
  parameter int H_ACTIVE_P      = H_ACTIVE,
  parameter int V_TOTAL_P       = V_TOTAL,
  parameter int V_ACTIVE_P      = V_ACTIVE,
  parameter int V_SYNC_START_P  = V_SYNC_START,
  parameter int V_SYNC_END_P    = V_SYNC_END
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  output logic [H_W-1:0] cntHorizontal,
  output logic [V_W-1:0] cntVertical,
  output logic           pixelTick,
  output logic           videoOn,
  output logic           VSync,
  output logic           frameStart,
  output logic           running
);
  logic [1:0] state, state_nxt;
  logic       h_last, v_last, frame_last;

  assign h_last     = (cntHorizontal == H_W'(H_TOTAL_P - 1));
  assign v_last     = (cntVertical == V_W'(V_TOTAL_P - 1));
  assign frame_last = pixelTick && h_last && v_last;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (enable) state_nxt = ST_RUN;
      ST_RUN:      if (!enable) state_nxt = ST_STOPPING;
      ST_STOPPING: begin
        if (enable)          state_nxt = ST_RUN;
        else if (frame_last) state_nxt = ST_IDLE;
      end
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Divider is driven from the next state so CLK_DIV=1 ticks on the very
  // first RUN clock and the divider is cleared on the stopping edge.
  pixel_tick_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (state_nxt != ST_IDLE),
    .tick  (pixelTick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cntHorizontal <= '0;
      cntVertical   <= '0;
      frameStart    <= 1'b0;
    end else begin
      state      <= state_nxt;
      frameStart <= ((state == ST_IDLE) && (state_nxt == ST_RUN)) ||
                    ((state_nxt == ST_RUN) && frame_last);
      if (state_nxt == ST_IDLE) begin
        cntHorizontal <= '0;
        cntVertical   <= '0;
      end else if (pixelTick) begin
        if (h_last) begin
          cntHorizontal <= '0;
          cntVertical   <= v_last ? '0 : cntVertical + 1'b1;
        end else begin
          cntHorizontal <= cntHorizontal + 1'b1;
        end
      end
    end
  end

  assign running = (state == ST_RUN) || (state == ST_STOPPING);
  assign videoOn = running && (cntHorizontal < H_W'(H_ACTIVE_P)) &&
                   (cntVertical < V_W'(V_ACTIVE_P));
  assign VSync   = !(running && (cntVertical >= V_W'(V_SYNC_START_P)) &&
                     (cntVertical <= V_W'(V_SYNC_END_P)));
endmodule

// File: tb/tb_vga_timing_controller.sv
// Bench for vga_timing_controller: two reduced-geometry instances (divide by
// 1 and by 4) checked every clock against a frame-position reference model.
module tb_vga_timing_controller;
  localparam int H  = 40;
  localparam int HA = 32;
  localparam int V  = 14;
  localparam int VA = 10;
  localparam int VS = 11;
  localparam int VE = 12;
  localparam int FRAME = H * V;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] en;
  logic [1:0][10:0] oh;
  logic [1:0][9:0]  ov;
  logic [1:0] opt, ovo, ovs, ofs, orn;

  always #5 clk = ~clk;

  vga_timing_controller #(.CLK_DIV(1), .H_TOTAL_P(H), .H_ACTIVE_P(HA), .V_TOTAL_P(V),
    .V_ACTIVE_P(VA), .V_SYNC_START_P(VS), .V_SYNC_END_P(VE)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(en[0]), .cntHorizontal(oh[0]), .cntVertical(ov[0]),
    .pixelTick(opt[0]), .videoOn(ovo[0]), .VSync(ovs[0]), .frameStart(ofs[0]), .running(orn[0]));

  vga_timing_controller #(.CLK_DIV(4), .H_TOTAL_P(H), .H_ACTIVE_P(HA), .V_TOTAL_P(V),
    .V_ACTIVE_P(VA), .V_SYNC_START_P(VS), .V_SYNC_END_P(VE)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(en[1]), .cntHorizontal(oh[1]), .cntVertical(ov[1]),
    .pixelTick(opt[1]), .videoOn(ovo[1]), .VSync(ovs[1]), .frameStart(ofs[1]), .running(orn[1]));

  int compared = 0;
  int mism = 0;

  // Reference model: active / stop-requested flags, linear position inside
  // the frame, and clocks spent active (the tick falls on every div-th one).
  bit m_act[2], m_stop[2], m_tick[2], m_fs[2];
  int m_pos[2], m_n[2];

  function automatic int divof(int i);
    return (i == 0) ? 1 : 4;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_stop[i] = 0; m_tick[i] = 0; m_fs[i] = 0; m_pos[i] = 0; m_n[i] = 0;
    end
  endtask

  task automatic model_clock();
    for (int i = 0; i < 2; i++) begin
      bit tk;
      tk = m_tick[i];
      m_fs[i] = 0;
      if (!m_act[i]) begin
        if (en[i]) begin
          m_act[i] = 1; m_stop[i] = 0; m_fs[i] = 1; m_pos[i] = 0; m_n[i] = 0;
        end
      end else begin
        bit last;
        last = tk && (m_pos[i] == FRAME - 1);
        if (m_stop[i] && !en[i] && last) begin
          m_act[i] = 0; m_pos[i] = 0; m_n[i] = 0;
        end else begin
          if (tk) m_pos[i] = last ? 0 : m_pos[i] + 1;
          m_fs[i] = en[i] && last;
          m_stop[i] = !en[i];
        end
      end
      if (m_act[i]) m_n[i]++;
      m_tick[i] = m_act[i] && (m_n[i] % divof(i) == 0);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      int eh, ev;
      eh = m_act[i] ? m_pos[i] % H : 0;
      ev = m_act[i] ? m_pos[i] / H : 0;
      chk($sformatf("d%0d.cntH", i), 32'(oh[i]), 32'(eh));
      chk($sformatf("d%0d.cntV", i), 32'(ov[i]), 32'(ev));
      chk($sformatf("d%0d.tick", i), 32'(opt[i]), 32'(m_tick[i]));
      chk($sformatf("d%0d.videoOn", i), 32'(ovo[i]), 32'(m_act[i] && eh < HA && ev < VA));
      chk($sformatf("d%0d.VSync", i), 32'(ovs[i]), 32'(!(m_act[i] && ev >= VS && ev <= VE)));
      chk($sformatf("d%0d.frameStart", i), 32'(ofs[i]), 32'(m_fs[i]));
      chk($sformatf("d%0d.running", i), 32'(orn[i]), 32'(m_act[i]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_clock();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int f1, f2, von, vsl, lt, guard, cyc, fsc;
    rst_n = 1'b0; en = 2'b00;
    model_reset();
    #1 compare_all();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (4) step();

    // start both; first RUN clock carries frameStart, counters begin at 0
    en = 2'b11;
    step();
    chk("start.frameStart", 32'(ofs[0]), 32'd1);
    step();
    chk("start.cntH_1", 32'(oh[0]), 32'd1);
    f1 = 0; f2 = -1; von = 0; vsl = 0; lt = -1;
    for (int c = 1; c <= 2300; c++) begin
      if (f2 < 0) begin
        von += ovo[0];
        vsl += !ovs[0];
      end
      step();
      if (ofs[0] && f2 < 0) f2 = c + 1;
      if (opt[1]) begin
        if (lt >= 0 && c < 60) chk("div4.period", 32'(c - lt), 32'd4);
        lt = c;
      end
    end
    von += 1;  // first clock (0,0) was active video before the loop
    chk("frame.period", 32'(f2 - f1), 32'(FRAME));
    chk("frame.videoOn", 32'(von), 32'(HA * VA));
    chk("frame.vsyncLow", 32'(vsl), 32'(2 * H));

    // random enable activity, including cancelled stops
    for (int c = 0; c < 8000; c++) begin
      for (int i = 0; i < 2; i++)
        if ($urandom_range(0, 999) < 3) en[i] = ~en[i];
      step();
    end

    // directed frame-aligned stop requested on line 5
    en = 2'b11;
    guard = 0;
    while (!(m_act[0] && m_pos[0] / H == 5 && !m_stop[0]) && guard < 3000) begin step(); guard++; end
    chk("stop.reach_line5", 32'(guard < 3000), 32'd1);
    en[0] = 1'b0;
    guard = 0;
    while (m_act[0] && guard < 3000) begin
      step(); guard++;
      if (m_act[0]) chk("stop.running_held", 32'(orn[0]), 32'd1);
    end
    chk("stop.timeout", 32'(guard < 3000), 32'd1);
    chk("stop.idle_running", 32'(orn[0]), 32'd0);
    chk("stop.idle_cntH", 32'(oh[0]), 32'd0);
    chk("stop.idle_cntV", 32'(ov[0]), 32'd0);
    chk("stop.idle_VSync", 32'(ovs[0]), 32'd1);
    chk("stop.idle_videoOn", 32'(ovo[0]), 32'd0);

    // 1->0->1 inside a frame: no stop, no extra frameStart
    en[0] = 1'b1;
    step();
    fsc = 0;
    en[0] = 1'b0; repeat (30) step();
    en[0] = 1'b1;
    for (int c = 0; c < FRAME - 40; c++) begin step(); fsc += ofs[0]; end
    chk("cancel.running", 32'(orn[0]), 32'd1);
    chk("cancel.no_extra_fs", 32'(fsc), 32'd0);

    // async reset mid-frame at (7,20)
    guard = 0;
    while (!(m_act[0] && m_pos[0] == 7 * H + 20) && guard < 3000) begin step(); guard++; end
    chk("rst.reach_point", 32'(guard < 3000), 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst.async_cntH", 32'(oh[0]), 32'd0);
    chk("rst.async_VSync", 32'(ovs[0]), 32'd1);
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst.restart_fs", 32'(ofs[0]), 32'd1);
    cyc = 0;
    repeat (20) begin step(); cyc++; end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule

// File: doc/vga_timing_controller.md
Name: vga_timing_controller

Overview:
Sequencing block for the VGA output path. Owns the horizontal and vertical pixel counters and drives cntHorizontal into generadorHsync, which produces HSync. Generates VSync, the active-video enable and a frame-start strobe. Provides frame-aligned start and stop of scanning, with an optional clock divider that produces the pixel tick.

Parameters:
CLK_DIV, 1, system clocks per pixel tick (>=1)
H_TOTAL, 1600, horizontal period in ticks; cntHorizontal range 0..H_TOTAL-1
H_ACTIVE, 1280, visible columns 0..H_ACTIVE-1
V_TOTAL, 521, vertical period in lines; cntVertical range 0..V_TOTAL-1
V_ACTIVE, 480, visible lines 0..V_ACTIVE-1
V_SYNC_START, 490, first line with VSync low
V_SYNC_END, 491, last line with VSync low

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  level request: 1 = scan, 0 = stop at end of frame
cntHorizontal  out  11  horizontal counter; feeds generadorHsync
cntVertical  out  10  vertical counter
pixelTick  out  1  one-clk strobe; counters advance on it
videoOn  out  1  1 when (cntHorizontal<H_ACTIVE && cntVertical<V_ACTIVE) and state != IDLE
VSync  out  1  0 when V_SYNC_START<=cntVertical<=V_SYNC_END and state != IDLE, else 1
frameStart  out  1  one-clk pulse marking the start of a frame
running  out  1  1 in RUN or STOPPING

Behaviour:
- Reset (async, rst_n=0): state=IDLE; divider=0; cntHorizontal=0; cntVertical=0; pixelTick=0; frameStart=0; videoOn=0; VSync=1; running=0. Release is sampled on the next clk edge.
- FSM states: IDLE, RUN, STOPPING.
  - IDLE -> RUN when enable=1. The transition takes effect on the next clk, and frameStart=1 for that first RUN clk.
  - RUN -> STOPPING when enable=0.
  - STOPPING -> RUN when enable=1. This cancels the stop; counters are not disturbed and frameStart is not pulsed.
  - STOPPING -> IDLE on the tick where cntHorizontal=H_TOTAL-1 and cntVertical=V_TOTAL-1. Counters load 0 and frameStart is not pulsed.
- Divider (runs only in RUN/STOPPING; held at 0 in IDLE):
  - Counts 0..CLK_DIV-1.
  - pixelTick is registered and high for one clk when the divider wraps.
  - CLK_DIV=1 gives pixelTick=1 on every running clk, starting with the first clk after entering RUN.
- Counters (advance only on clk edges where pixelTick=1):
  - cntHorizontal increments; at H_TOTAL-1 it wraps to 0 and cntVertical increments.
  - cntVertical wraps from V_TOTAL-1 to 0 at the same point.
  - Counter values never exceed H_TOTAL-1 or V_TOTAL-1.
  - In IDLE both counters are held at 0.
- frameStart also pulses for the one clk following a counter wrap (V_TOTAL-1, H_TOTAL-1) -> (0,0) while in RUN.
- videoOn, VSync and running are combinational decodes of the registered counters and state, with zero latency relative to the counters.
- HSync is not generated here. Its timing (high for cntHorizontal 1..1408) follows from cntHorizontal, so the horizontal period must stay at H_TOTAL=1600.
- Simultaneous events:
  - enable toggling 1->0->1 inside one frame means no stop.
  - enable=0 in the same clk as the final tick of the frame: the request is registered in RUN, goes to STOPPING, and stops at the end of the following frame.
- rst_n asserted mid-frame forces all outputs to their reset values immediately.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, STOPPING=2'd2);
  - default timing constants H_TOTAL, H_ACTIVE, V_TOTAL, V_ACTIVE, V_SYNC_START, V_SYNC_END;
  - counter widths (11, 10).
- One natural sub-module, pixel_tick_divider: divider plus pixelTick register, with clk, rst_n and run inputs.
- The FSM and counters stay in the top module.
- The top instantiates generadorHsync only in the integration wrapper, not inside this block.

Test Plan:
1. Reset, then enable=1 with CLK_DIV=1 -> frameStart=1 on the first RUN clk; cntHorizontal reads 1 one clk later; cntHorizontal=1599->0 with cntVertical 0->1 after 1600 ticks.
2. Full frame at defaults -> videoOn=1 for exactly 1280x480 ticks; VSync=0 for exactly 2x1600 ticks (lines 490,491); the second frameStart comes 833,600 ticks after the first.
3. CLK_DIV=4 -> pixelTick period is 4 clks; cntHorizontal advances once per 4 clks; divider stays at 0 in IDLE.
4. enable=0 at line 100 -> running stays 1 until the (520,1599) tick, then IDLE with counters at (0,0), VSync=1 and videoOn=0.
5. enable 1->0->1 within the frame (STOPPING then RUN) -> no stop; counter sequence is continuous; no extra frameStart.
6. rst_n pulsed low at (300,700) -> counters read 0 and VSync=1 asynchronously; after release with enable=1 -> restart with frameStart.
